// File: rtl/dct4_pkg.sv
// rtl/dct4_pkg.sv - shared state encoding, mode constants and width rule for dct4_stream
package dct4_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic MODE_DCT = 1'b0;
  localparam logic MODE_WHT = 1'b1;

  // Three guard bits hold the worst case |y1| = 3*(2^IN_W - 1) exactly.
  localparam int OUT_W_GUARD = 3;

  function automatic int out_width(input int in_w);
    return in_w + OUT_W_GUARD;
  endfunction

endpackage

// File: rtl/dct4_butterfly.sv
// rtl/dct4_butterfly.sv - combinational 4-point integer DCT / Walsh-Hadamard butterfly
module dct4_butterfly
  import dct4_pkg::*;
#(
  parameter  int IN_W  = 4,
  localparam int OUT_W = out_width(IN_W)
) (
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  x1,
  input  logic signed [IN_W-1:0]  x2,
  input  logic signed [IN_W-1:0]  x3,
  input  logic                    mode,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  logic signed [OUT_W-1:0] e0, e1, e2, e3;
  logic signed [OUT_W-1:0] s0, s1, d0, d1;

  assign e0 = {{(OUT_W-IN_W){x0[IN_W-1]}}, x0};
  assign e1 = {{(OUT_W-IN_W){x1[IN_W-1]}}, x1};
  assign e2 = {{(OUT_W-IN_W){x2[IN_W-1]}}, x2};
  assign e3 = {{(OUT_W-IN_W){x3[IN_W-1]}}, x3};

  assign s0 = e0 + e3;
  assign s1 = e1 + e2;
  assign d0 = e0 - e3;
  assign d1 = e1 - e2;

  always_comb begin
    y0 = s0 + s1;
    y2 = s0 - s1;
    if (mode == MODE_WHT) begin
      y1 = d0 + d1;
      y3 = d0 - d1;
    end else begin
      y1 = d0 + d0 + d1;
      y3 = d0 - d1 - d1;
    end
  end

endmodule

// File: rtl/dct4_stream.sv
// rtl/dct4_stream.sv - streaming 4-point transform: collect 4 samples, compute, emit 4 coefficients
module dct4_stream
  import dct4_pkg::*;
#(
  parameter  int IN_W  = 4,
  localparam int OUT_W = out_width(IN_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last
);

  state_t                  state, state_n;
  logic [1:0]              cnt;
  logic                    mode_q;
  logic signed [IN_W-1:0]  x_q [4];
  logic signed [OUT_W-1:0] y_q [4];
  logic signed [OUT_W-1:0] y_c0, y_c1, y_c2, y_c3;

  dct4_butterfly #(.IN_W(IN_W)) u_butterfly (
    .x0   (x_q[0]),
    .x1   (x_q[1]),
    .x2   (x_q[2]),
    .x3   (x_q[3]),
    .mode (mode_q),
    .y0   (y_c0),
    .y1   (y_c1),
    .y2   (y_c2),
    .y3   (y_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      cnt    <= 2'd0;
      mode_q <= MODE_DCT;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state <= state_n;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            x_q[cnt] <= in_data;
            if (cnt == 2'd0) mode_q <= in_mode;
            cnt <= cnt + 2'd1;
          end
        end
        COMPUTE: begin
          y_q[0] <= y_c0;
          y_q[1] <= y_c1;
          y_q[2] <= y_c2;
          y_q[3] <= y_c3;
        end
        EMIT: begin
          if (out_ready) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode only registered state, so in_valid/out_ready never reach them.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 2'd3) state_n = COMPUTE;
      end
      COMPUTE: state_n = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && cnt == 2'd3) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  assign out_data = y_q[cnt];
  assign out_last = (state == EMIT) && (cnt == 2'd3);

endmodule

// File: tb/tb_dct4_stream.sv
// tb/tb_dct4_stream.sv - directed and random self-checking bench for dct4_stream
module tb_dct4_stream;

  localparam int IN_W  = 4;
  localparam int OUT_W = IN_W + 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data = '0;
  logic                    in_mode = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  dct4_stream #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input logic m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    in_mode  = m;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input int exp, input int exp_last);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, out_data, exp);
    check({tag, "_last"}, out_last, exp_last);
    tick();
  endtask

  task automatic run_block(input string tag, input int x0, input int x1, input int x2, input int x3,
                           input logic m, input int y0, input int y1, input int y2, input int y3);
    push(x0, m);
    push(x1, ~m);
    push(x2, m);
    push(x3, ~m);
    pop({tag, "_y0"}, y0, 0);
    pop({tag, "_y1"}, y1, 0);
    pop({tag, "_y2"}, y2, 0);
    pop({tag, "_y3"}, y3, 1);
  endtask

  function automatic int ref_y(input int x0, input int x1, input int x2, input int x3,
                               input logic m, input int k);
    int s0, s1, d0, d1;
    s0 = x0 + x3;
    s1 = x1 + x2;
    d0 = x0 - x3;
    d1 = x1 - x2;
    case (k)
      0:       return s0 + s1;
      1:       return m ? d0 + d1 : 2 * d0 + d1;
      2:       return s0 - s1;
      default: return m ? d0 - d1 : d0 - 2 * d1;
    endcase
  endfunction

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);

    // DCT [1,2,3,4] with explicit latency checks around COMPUTE
    out_ready = 1'b1;
    push(1, 1'b0);
    push(2, 1'b0);
    push(3, 1'b0);
    push(4, 1'b0);
    check("lat_compute_valid", out_valid, 0);
    check("lat_compute_ready", in_ready, 0);
    tick();
    check("lat_emit_valid", out_valid, 1);
    check("lat_emit_y0", out_data, 10);
    pop("dct_y0", 10, 0);
    pop("dct_y1", -7, 0);
    pop("dct_y2", 0, 0);
    pop("dct_y3", -1, 1);
    check("dct_ready_after", in_ready, 1);
    check("dct_valid_after", out_valid, 0);

    run_block("wht", 1, 2, 3, 4, 1'b1, 10, -4, 0, -2);
    run_block("dct_tog", 1, 2, 3, 4, 1'b0, 10, -7, 0, -1);
    run_block("ext_a", -8, 7, 7, -8, 1'b0, -2, 0, -30, 0);
    run_block("ext_b", 7, -8, -8, 7, 1'b0, -2, 0, 30, 0);
    run_block("ext_c", 7, 7, -8, -8, 1'b0, -2, 45, 0, -15);
    run_block("ext_d", -8, -8, 7, 7, 1'b0, -2, -45, 0, 15);
    run_block("ext_w", 7, -8, 7, -8, 1'b1, -2, 0, 0, 30);

    // Backpressure on y1
    push(1, 1'b0);
    push(2, 1'b0);
    push(3, 1'b0);
    push(4, 1'b0);
    pop("bp_y0", 10, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, -7);
      check("bp_last", out_last, 0);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    pop("bp_y1", -7, 0);
    pop("bp_y2", 0, 0);
    pop("bp_y3", -1, 1);

    // Reset with a partial block pending
    push(5, 1'b1);
    push(-3, 1'b1);
    push(6, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    run_block("post_rst", 1, 2, 3, 4, 1'b0, 10, -7, 0, -1);

    // Back-to-back random blocks with random backpressure
    fork
      begin
        for (int b = 0; b < 100; b++) begin
          int x[4];
          logic m;
          logic signed [IN_W-1:0] v;
          m = 1'($urandom_range(0, 1));
          for (int i = 0; i < 4; i++) begin
            v = IN_W'($urandom_range(0, 15));
            x[i] = v;
            push(x[i], (i == 0) ? m : 1'($urandom_range(0, 1)));
            in_valid = 1'b1;
          end
          for (int k = 0; k < 4; k++) exp_q.push_back(ref_y(x[0], x[1], x[2], x[3], m, k));
        end
        in_valid = 1'b0;
      end
      begin
        int got_n;
        int cyc;
        int e;
        got_n = 0;
        cyc = 0;
        while (got_n < 400 && cyc < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("rand_data", out_data, e);
            end else begin
              check("rand_extra", out_data, 9999);
            end
            check("rand_last", out_last, (got_n % 4 == 3) ? 1 : 0);
            got_n++;
          end
          tick();
          cyc++;
        end
        check("rand_count", got_n, 400);
      end
    join
    check("rand_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
